// File: rtl/mem_access_pkg.sv
// Shared definitions for the MIPS MEM stage: memory op encodings, FSM states,
// register-file widths and small op-classification helpers.
package mem_access_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LBU = 4'd2,
    MEM_LH  = 4'd3,
    MEM_LHU = 4'd4,
    MEM_LW  = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic op_is_load(logic [3:0] op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic op_is_store(logic [3:0] op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic op_is_half(logic [3:0] op);
    return op inside {MEM_LH, MEM_LHU, MEM_SH};
  endfunction

  function automatic logic op_is_word(logic [3:0] op);
    return op inside {MEM_LW, MEM_SW};
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus request/acknowledge interface between the MEM stage (master) and
// the data memory (slave).
interface mem_access_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_sel;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_lane_fmt.sv
// Big-endian byte-lane steering: byte enables and replicated store data for
// the bus, lane select plus sign/zero extension for loads.
module mem_lane_fmt
  import mem_access_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_a,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  always_comb begin
    case (i_a)
      2'd0:    w_byte = i_rdata[31:24];
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
    // Halfword lanes use a[1] only; a misaligned a[0] is masked here.
    w_half = i_a[1] ? i_rdata[15:0] : i_rdata[31:16];
  end

  always_comb begin
    o_sel       = 4'b1111;
    o_wdata     = i_store_data;
    o_load_data = i_rdata;
    case (i_op)
      MEM_LB, MEM_LBU, MEM_SB: begin
        o_sel   = 4'b1000 >> i_a;
        o_wdata = {4{i_store_data[7:0]}};
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        o_sel   = i_a[1] ? 4'b0011 : 4'b1100;
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
    case (i_op)
      MEM_LB:  o_load_data = 32'($signed(w_byte));
      MEM_LBU: o_load_data = {24'd0, w_byte};
      MEM_LH:  o_load_data = 32'($signed(w_half));
      MEM_LHU: o_load_data = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MIPS MEM stage: pass-through for non-memory ops, request/ack bus transaction
// with stall for loads/stores. Define MEM_ALIGN_EXC_EN to trap misaligned ops.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [3:0]            ex_mem_op,
  input  logic [ADDR_W-1:0]     ex_mem_addr,
  input  logic [RegBus-1:0]     ex_store_data,
  input  logic [RegAddrBus-1:0] ex_waddr,
  input  logic                  ex_wen,
  input  logic [RegBus-1:0]     ex_wdata,
  input  logic                  ex_hilo_wen,
  input  logic [RegBus-1:0]     ex_hi,
  input  logic [RegBus-1:0]     ex_lo,
  output logic [RegAddrBus-1:0] mem_waddr,
  output logic                  mem_wen,
  output logic [RegBus-1:0]     mem_wdata,
  output logic                  mem_hilo_wen,
  output logic [RegBus-1:0]     mem_hi_o,
  output logic [RegBus-1:0]     mem_lo_o,
  output logic                  stallreq,
  mem_access_if.master          bus
`ifdef MEM_ALIGN_EXC_EN
  ,
  output logic                  misalign
`endif
);

  state_e            r_state, w_next;
  logic              r_req, r_we, r_kill;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_sel, w_sel;
  logic [31:0]       r_wdata, w_wdata, r_result, w_load_data;
  logic [1:0]        w_a;
  logic              w_is_mem, w_is_load, w_misalign, w_start;

  assign w_a       = ex_mem_addr[1:0];
  assign w_is_load = op_is_load(ex_mem_op);
  assign w_is_mem  = w_is_load | op_is_store(ex_mem_op);

`ifdef MEM_ALIGN_EXC_EN
  assign w_misalign = (op_is_half(ex_mem_op) && w_a[0]) ||
                      (op_is_word(ex_mem_op) && (w_a != 2'd0));
  assign misalign   = (r_state == IDLE) && w_is_mem && !flush && w_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start = (r_state == IDLE) && w_is_mem && !flush && !w_misalign;

  mem_lane_fmt u_lane_fmt (
    .i_op        (ex_mem_op),
    .i_a         (w_a),
    .i_store_data(ex_store_data),
    .i_rdata     (bus.bus_rdata),
    .o_sel       (w_sel),
    .o_wdata     (w_wdata),
    .o_load_data (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    mem_waddr    = ex_waddr;
    mem_wen      = ex_wen;
    mem_wdata    = ex_wdata;
    mem_hilo_wen = ex_hilo_wen;
    mem_hi_o     = ex_hi;
    mem_lo_o     = ex_lo;
    stallreq     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_is_mem || flush) begin
          mem_wen      = 1'b0;
          mem_hilo_wen = 1'b0;
        end
        if (w_start) begin
          stallreq = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY: begin
        stallreq     = 1'b1;
        mem_wen      = 1'b0;
        mem_hilo_wen = 1'b0;
        if (bus.bus_ack) w_next = DONE;
      end
      DONE: begin
        mem_wen      = ex_wen && w_is_load && !r_kill && !flush;
        mem_wdata    = r_result;
        mem_hilo_wen = 1'b0;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Bus fields are launched once at the IDLE->BUSY edge and held until ack;
  // a flush seen while BUSY only marks the result as dead.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_sel    <= '0;
      r_wdata  <= ZeroWord;
      r_result <= ZeroWord;
      r_kill   <= 1'b0;
    end else begin
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= op_is_store(ex_mem_op);
        r_addr  <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
        r_sel   <= w_sel;
        r_wdata <= w_wdata;
        r_kill  <= 1'b0;
      end
      if (r_state == BUSY) begin
        if (flush) r_kill <= 1'b1;
        if (bus.bus_ack) begin
          r_req    <= 1'b0;
          r_result <= w_load_data;
        end
      end
    end
  end

  assign bus.bus_req   = r_req;
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_sel   = r_sel;
  assign bus.bus_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed and randomized loads/stores
// against an arithmetic lane/extension reference model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr, ex_store_data, ex_wdata, ex_hi, ex_lo;
  logic [4:0]  ex_waddr;
  logic        ex_wen, ex_hilo_wen;
  logic [4:0]  mem_waddr;
  logic        mem_wen, mem_hilo_wen, stallreq;
  logic [31:0] mem_wdata, mem_hi_o, mem_lo_o;
`ifdef MEM_ALIGN_EXC_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  mem_access_if #(.ADDR_W(32)) bus ();

  mem_access #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ex_mem_op    (ex_mem_op),
    .ex_mem_addr  (ex_mem_addr),
    .ex_store_data(ex_store_data),
    .ex_waddr     (ex_waddr),
    .ex_wen       (ex_wen),
    .ex_wdata     (ex_wdata),
    .ex_hilo_wen  (ex_hilo_wen),
    .ex_hi        (ex_hi),
    .ex_lo        (ex_lo),
    .mem_waddr    (mem_waddr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_hilo_wen (mem_hilo_wen),
    .mem_hi_o     (mem_hi_o),
    .mem_lo_o     (mem_lo_o),
    .stallreq     (stallreq),
    .bus          (bus)
`ifdef MEM_ALIGN_EXC_EN
    ,
    .misalign     (misalign)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: access size in bytes, aligned offset, then shifts/masks.
  function automatic int ref_size(logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      default:                 return 4;
    endcase
  endfunction

  function automatic int ref_off(logic [3:0] op, logic [31:0] addr);
    int b = ref_size(op);
    int a = int'(addr[1:0]);
    return a - (a % b);
  endfunction

  function automatic logic [31:0] ref_mask(int b);
    return (b == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * b)) - 32'd1);
  endfunction

  function automatic logic [3:0] ref_sel(logic [3:0] op, logic [31:0] addr);
    int b = ref_size(op);
    int off = ref_off(op, addr);
    int v = ((1 << b) - 1) << (4 - off - b);
    return v[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(logic [3:0] op, logic [31:0] sdata);
    int b = ref_size(op);
    logic [31:0] piece = sdata & ref_mask(b);
    logic [31:0] r = '0;
    for (int i = 0; i < 4 / b; i++) r |= piece << (8 * b * i);
    return r;
  endfunction

  function automatic logic [31:0] ref_load(logic [3:0] op, logic [31:0] addr,
                                           logic [31:0] rdata);
    int b = ref_size(op);
    logic [31:0] m = ref_mask(b);
    logic [31:0] v = (rdata >> (8 * (4 - ref_off(op, addr) - b))) & m;
    if ((op == MEM_LB || op == MEM_LH) && v[8 * b - 1]) v |= ~m;
    return v;
  endfunction

  // One memory op: IDLE cycle, n+1 BUSY cycles (ack in the last), then DONE.
  task automatic do_mem(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int n, input logic wen, input logic [4:0] waddr,
                        input int flush_at, input string tag);
    int          stall_cnt;
    bit          is_ld, is_st, killed;
    logic [37:0] exp_bus;
    logic [37:0] got_bus;
    logic        exp_wen;
    is_ld  = op_is_load(op);
    is_st  = op_is_store(op);
    killed = (flush_at >= 0) && (flush_at <= n);
    exp_bus = {1'b1, is_st, addr & 32'hFFFF_FFFC, ref_sel(op, addr)};
    @(posedge clk); #1;
    ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sdata;
    ex_wen = wen; ex_waddr = waddr; ex_wdata = $urandom;
    ex_hilo_wen = 1'b1; ex_hi = $urandom; ex_lo = $urandom;
    @(negedge clk);
    stall_cnt = stallreq ? 1 : 0;
    checks++;
    if (bus.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL %s req_in_idle: got %b want 0", tag, bus.bus_req);
    end
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #1;
      flush = (k == flush_at);
      if (k == n) begin
        bus.bus_ack = 1'b1; bus.bus_rdata = rdata;
      end else begin
        bus.bus_ack = 1'b0; bus.bus_rdata = $urandom;
      end
      @(negedge clk);
      if (stallreq) stall_cnt++;
      got_bus = {bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_sel};
      checks++;
      if (got_bus !== exp_bus) begin
        errors++;
        $display("FAIL %s bus_fields cyc%0d: got %h want %h", tag, k, got_bus, exp_bus);
      end
      if (is_st) begin
        checks++;
        if (bus.bus_wdata !== ref_wdata(op, sdata)) begin
          errors++;
          $display("FAIL %s bus_wdata: got %h want %h", tag, bus.bus_wdata,
                   ref_wdata(op, sdata));
        end
      end
    end
    @(posedge clk); #1;
    bus.bus_ack = 1'b0; flush = 1'b0;
    @(negedge clk);
    exp_wen = wen && is_ld && !killed;
    checks++;
    if (stall_cnt != n + 2) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cnt, n + 2);
    end
    checks++;
    if ({stallreq, bus.bus_req, mem_hilo_wen} !== 3'b000) begin
      errors++;
      $display("FAIL %s done_ctrl: got stall=%b req=%b hilo=%b want 000", tag,
               stallreq, bus.bus_req, mem_hilo_wen);
    end
    checks++;
    if (mem_wen !== exp_wen || mem_waddr !== waddr) begin
      errors++;
      $display("FAIL %s done_wen: got wen=%b waddr=%0d want wen=%b waddr=%0d", tag,
               mem_wen, mem_waddr, exp_wen, waddr);
    end
    if (is_ld && !killed) begin
      checks++;
      if (mem_wdata !== ref_load(op, addr, rdata)) begin
        errors++;
        $display("FAIL %s load_data: got %h want %h", tag, mem_wdata,
                 ref_load(op, addr, rdata));
      end
    end
    @(posedge clk); #1;
    ex_mem_op = MEM_NOP;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; ex_mem_op = MEM_NOP; ex_mem_addr = '0;
    ex_store_data = '0; ex_waddr = '0; ex_wen = 1'b0; ex_wdata = '0;
    ex_hilo_wen = 1'b0; ex_hi = '0; ex_lo = '0;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.bus_req, bus.bus_we, bus.bus_sel, bus.bus_addr, bus.bus_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got req=%b we=%b sel=%b addr=%h wdata=%h want all 0",
               bus.bus_req, bus.bus_we, bus.bus_sel, bus.bus_addr, bus.bus_wdata);
    end
    checks++;
    if ({mem_waddr, mem_wen, stallreq} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outs: got waddr=%0d wen=%b stall=%b want 0", mem_waddr,
               mem_wen, stallreq);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_nop();
    @(posedge clk); #1;
    ex_mem_op = MEM_NOP; ex_waddr = 5'd3; ex_wdata = 32'h1234; ex_wen = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_wdata !== 32'h1234 || mem_wen !== 1'b1 || stallreq !== 1'b0 || mem_waddr !== 5'd3) begin
      errors++;
      $display("FAIL nop_pass: got wdata=%h wen=%b stall=%b waddr=%0d want 1234 1 0 3",
               mem_wdata, mem_wen, stallreq, mem_waddr);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ex_waddr = 5'($urandom); ex_wdata = $urandom; ex_wen = 1'($urandom);
      ex_hilo_wen = 1'($urandom); ex_hi = $urandom; ex_lo = $urandom;
      flush = (i == 3);
      @(negedge clk);
      checks++;
      if ({mem_waddr, mem_wen, mem_wdata, mem_hilo_wen, mem_hi_o, mem_lo_o} !==
          {ex_waddr, ex_wen && !flush, ex_wdata, ex_hilo_wen && !flush, ex_hi, ex_lo}) begin
        errors++;
        $display("FAIL nop_rand%0d: got wen=%b hilo=%b wdata=%h want wen=%b hilo=%b wdata=%h",
                 i, mem_wen, mem_hilo_wen, mem_wdata, ex_wen && !flush,
                 ex_hilo_wen && !flush, ex_wdata);
      end
    end
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_directed();
    do_mem(MEM_LB, 32'h101, 32'h0, 32'h11F2_3344, 3, 1'b1, 5'd7, -1, "lb_0x101");
    do_mem(MEM_SH, 32'h202, 32'h0000_ABCD, 32'h0, 0, 1'b1, 5'd9, -1, "sh_0x202");
    do_mem(MEM_LHU, 32'h10, 32'h0, 32'h8001_0000, 1, 1'b1, 5'd4, -1, "lhu_0x10");
    do_mem(MEM_LH, 32'h12, 32'h0, 32'h1234_8001, 0, 1'b1, 5'd5, -1, "lh_0x12");
    do_mem(MEM_SB, 32'h83, 32'h0000_005A, 32'h0, 2, 1'b0, 5'd6, -1, "sb_0x83");
  endtask

  task automatic test_flush();
    do_mem(MEM_LW, 32'h400, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 5'd8, 0, "flush_busy");
    @(posedge clk); #1;
    ex_mem_op = MEM_LW; ex_mem_addr = 32'h44; ex_wen = 1'b1; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (stallreq !== 1'b0 || mem_wen !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got stall=%b wen=%b want 0 0", stallreq, mem_wen);
    end
    @(posedge clk); #1;
    ex_mem_op = MEM_NOP; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_req: got %b want 0", bus.bus_req);
    end
  endtask

  task automatic test_reset_busy();
    @(posedge clk); #1;
    ex_mem_op = MEM_SW; ex_mem_addr = 32'h40; ex_store_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.bus_req !== 1'b1) begin
      errors++;
      $display("FAIL rstbusy_pre: got req=%b want 1", bus.bus_req);
    end
    @(posedge clk); #1;
    rst = 1'b0; ex_mem_op = MEM_NOP; ex_wdata = 32'h0BAD_CAFE; ex_wen = 1'b1;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if ({bus.bus_req, bus.bus_sel, bus.bus_addr, stallreq} !== '0) begin
      errors++;
      $display("FAIL rstbusy_clear: got req=%b sel=%b addr=%h stall=%b want 0",
               bus.bus_req, bus.bus_sel, bus.bus_addr, stallreq);
    end
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_wdata !== 32'h0BAD_CAFE || mem_wen !== 1'b1 || bus.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL rstbusy_ackign: got wdata=%h wen=%b req=%b want 0badcafe 1 0",
               mem_wdata, mem_wen, bus.bus_req);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_ALIGN_EXC_EN
    @(posedge clk); #1;
    ex_mem_op = MEM_LW; ex_mem_addr = 32'h3; ex_wen = 1'b1;
    @(negedge clk);
    checks++;
    if (misalign !== 1'b1 || stallreq !== 1'b0 || mem_wen !== 1'b0) begin
      errors++;
      $display("FAIL misalign_lw: got mis=%b stall=%b wen=%b want 1 0 0", misalign,
               stallreq, mem_wen);
    end
    @(posedge clk); #1;
    ex_mem_op = MEM_LH; ex_mem_addr = 32'h1;
    @(negedge clk);
    checks++;
    if (misalign !== 1'b1 || bus.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL misalign_lh: got mis=%b req=%b want 1 0", misalign, bus.bus_req);
    end
    @(posedge clk); #1;
    ex_mem_op = MEM_NOP;
    @(negedge clk);
    checks++;
    if (misalign !== 1'b0 || bus.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL misalign_after: got mis=%b req=%b want 0 0", misalign, bus.bus_req);
    end
`else
    do_mem(MEM_LW, 32'h103, 32'h0, 32'h89AB_CDEF, 1, 1'b1, 5'd10, -1, "lw_unaligned");
    do_mem(MEM_LH, 32'h1, 32'h0, 32'h89AB_CDEF, 0, 1'b1, 5'd11, -1, "lh_unaligned");
`endif
  endtask

  task automatic test_random();
    logic [3:0]  ops [8] = '{MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW};
    logic [3:0]  op;
    logic [31:0] addr;
    int          n, fa;
    for (int i = 0; i < 24; i++) begin
      op   = ops[$urandom_range(0, 7)];
      addr = $urandom;
`ifdef MEM_ALIGN_EXC_EN
      addr = addr & ~(32'(ref_size(op)) - 32'd1);
`endif
      n  = $urandom_range(0, 3);
      fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n) : -1;
      do_mem(op, addr, $urandom, $urandom, n, 1'($urandom), 5'($urandom), fa, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_directed();
    test_flush();
    test_reset_busy();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
